// File: rtl/t5_hart_sched.sv
// rtl/t5_hart_sched.sv - round-robin hart scheduler for the barrel pipeline
//
// Tracks per-hart state (IDLE/RUN/WAIT/TRAP) and issues one RUN hart per
// enabled cycle in round-robin order after the last issued hart.
//
// Ports:
//   sclk, srst       clock (rising edge), asynchronous active-low reset
//   sena             pipeline enable: gates issue, pointer and trap countdown
//   hrun[3:0]        per-hart run mask
//   wreq/whart       memory stall request for a hart
//   wack/ahart       memory completion for a hart
//   xtrap/thart      trap / misalign redirect for a hart
//   dhart, dvld      registered issued hart ID and its valid
//   hstat[7:0]       per-hart state, hart h at [2h+1:2h]
//   hidle            registered: no hart outside IDLE
module t5_hart_sched #(
  parameter int NHART = 4,
  parameter int TDLY  = 3
) (
  input  logic       sclk,
  input  logic       srst,
  input  logic       sena,
  input  logic [3:0] hrun,
  input  logic       wreq,
  input  logic [1:0] whart,
  input  logic       wack,
  input  logic [1:0] ahart,
  input  logic       xtrap,
  input  logic [1:0] thart,
  output logic [1:0] dhart,
  output logic       dvld,
  output logic [7:0] hstat,
  output logic       hidle
);

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    WAIT = 2'b10,
    TRAP = 2'b11
  } hst_t;

  hst_t       st   [NHART];
  hst_t       nst  [NHART];
  logic [2:0] cnt  [NHART];
  logic [2:0] ncnt [NHART];
  logic [1:0] lptr;

  logic [3:0] hx, hw, ha;
  logic       all_idle;
  logic       pick_vld;
  logic [1:0] pick;
  logic [1:0] idx;

  // One-hot decode of the per-hart event strobes.
  assign hx = xtrap ? (4'b0001 << thart) : 4'b0000;
  assign hw = wreq  ? (4'b0001 << whart) : 4'b0000;
  assign ha = wack  ? (4'b0001 << ahart) : 4'b0000;

  // Next-state per hart. Priority xtrap > wreq > wack > hrun.
  always_comb begin
    all_idle = 1'b1;
    for (int h = 0; h < NHART; h++) begin
      nst[h]  = st[h];
      ncnt[h] = cnt[h];
      case (st[h])
        IDLE: if (hrun[h]) nst[h] = RUN;
        RUN: begin
          if (hx[h]) begin
            nst[h]  = TRAP;
            ncnt[h] = 3'(TDLY);
          end else if (hw[h]) begin
            nst[h] = WAIT;
          end else if (!hrun[h]) begin
            nst[h] = IDLE;
          end
        end
        WAIT: begin
          if (hx[h]) begin
            nst[h]  = TRAP;
            ncnt[h] = 3'(TDLY);
          end else if (ha[h]) begin
            nst[h] = hrun[h] ? RUN : IDLE;
          end
        end
        TRAP: begin
          if (hx[h]) begin
            ncnt[h] = 3'(TDLY);
          end else if (!hrun[h]) begin
            nst[h]  = IDLE;
            ncnt[h] = 3'd0;
          end else if (sena) begin
            // Count reaching zero on this decrement releases the hart.
            if (cnt[h] <= 3'd1) begin
              nst[h]  = RUN;
              ncnt[h] = 3'd0;
            end else begin
              ncnt[h] = cnt[h] - 3'd1;
            end
          end
        end
        default: nst[h] = IDLE;
      endcase
      if (nst[h] != IDLE) all_idle = 1'b0;
    end
  end

  // Round-robin pick from registered state. Scanning offsets high to low
  // lets the nearest hart after lptr win; offset 4 wraps back to lptr.
  always_comb begin
    pick_vld = 1'b0;
    pick     = lptr;
    idx      = lptr;
    for (int k = NHART; k >= 1; k--) begin
      idx = lptr + 2'(k);
      if (st[idx] == RUN) begin
        pick_vld = 1'b1;
        pick     = idx;
      end
    end
  end

  always_comb begin
    hstat = 8'h00;
    for (int h = 0; h < NHART; h++) hstat[2*h +: 2] = st[h];
  end

  always_ff @(posedge sclk or negedge srst) begin
    if (!srst) begin
      for (int h = 0; h < NHART; h++) begin
        st[h]  <= IDLE;
        cnt[h] <= 3'd0;
      end
      lptr  <= 2'd3;
      dhart <= 2'd0;
      dvld  <= 1'b0;
      hidle <= 1'b1;
    end else begin
      for (int h = 0; h < NHART; h++) begin
        st[h]  <= nst[h];
        cnt[h] <= ncnt[h];
      end
      hidle <= all_idle;
      if (sena) begin
        dvld <= pick_vld;
        if (pick_vld) begin
          dhart <= pick;
          lptr  <= pick;
        end
      end
    end
  end

endmodule

// File: doc/t5_hart_sched.md
Name: t5_hart_sched

Overview:
- Round-robin hart scheduler for the barrel pipeline feeding the decode/ALU datapath. Each enabled cycle it picks which hart issues next and drives the hart ID the datapath uses for CSR reads (mhartid) and PC selection.
- Tracks a per-hart state: IDLE, RUN, WAIT (memory outstanding) or TRAP (flush after a misalign or exception redirect). Only RUN harts are issued.

Parameters:
- NHART, 4, number of harts. Fixed at 4 to match the 2-bit hart ID.
- TDLY, 3, cycles a hart stays in TRAP before returning to RUN, counted in sena cycles. Legal range 1..7.

Ports:
- sclk  in  1  clock, rising edge
- srst  in  1  reset, asynchronous, active-low
- sena  in  1  pipeline enable. Gates issue, pointer and trap countdown.
- hrun  in  4  per-hart run enable (software/debug mask)
- wreq  in  1  memory access stalls hart whart
- whart  in  2  hart for wreq
- wack  in  1  memory completion for hart ahart
- ahart  in  2  hart for wack
- xtrap  in  1  trap or misalign redirect for hart thart (from the ALU branch flags)
- thart  in  2  hart for xtrap
- dhart  out  2  issued hart ID, registered
- dvld  out  1  dhart valid this cycle, registered
- hstat  out  8  per-hart state, 2 bits per hart, hart h at [2h+1:2h]. IDLE=00, RUN=01, WAIT=10, TRAP=11.
- hidle  out  1  no hart in RUN, WAIT or TRAP, registered

Behaviour:
- Reset (srst=0, asynchronous):
  - all harts IDLE; trap counters 0; last-issued pointer lptr=3, so hart 0 has priority first.
  - dhart=0, dvld=0, hstat=0, hidle=1.
- Per-hart transitions, evaluated every clock regardless of sena so that wreq/wack/xtrap are never lost. Priority for the same hart in the same cycle is xtrap > wreq > wack > hrun.
  - IDLE -> RUN when hrun[h]=1.
  - RUN -> TRAP on xtrap. RUN -> WAIT on wreq. RUN -> IDLE when hrun[h]=0.
  - WAIT -> TRAP on xtrap. WAIT -> RUN on wack if hrun[h]=1, else IDLE. hrun=0 alone does not leave WAIT.
  - TRAP: counter loaded with TDLY on entry. It decrements on each sena cycle and the hart moves to RUN when the count reaches 0. A new xtrap while in TRAP reloads TDLY. hrun[h]=0 forces IDLE and clears the counter.
  - xtrap or wack addressed to an IDLE hart is ignored. wack to a RUN hart is ignored. wreq to a hart not in RUN is ignored.
  - wreq and wack in the same cycle to different harts are both applied.
- Issue, on sena=1 only:
  - search harts (lptr+1)..(lptr+4) mod 4; take the first whose current registered state is RUN.
  - If found: dhart<=hart, dvld<=1, lptr<=hart. Otherwise dvld<=0; dhart and lptr hold.
  - Eligibility uses pre-update state. A hart issued in the same cycle it receives wreq or xtrap is still issued once; its state changes next cycle.
  - Latency: a state change to RUN at edge N allows issue at edge N+1, visible on dhart after that edge.
  - With a single RUN hart it is issued every cycle. Wrap-around 3->0 is seamless.
- sena=0: dhart, dvld, lptr and trap counters hold. State transitions other than the TRAP countdown still occur.
- hidle<=1 when all next-state values are IDLE. Updated every clock.
- hstat reflects registered state with no extra latency.
- Reset asserted mid-operation aborts any WAIT/TRAP immediately. A wack arriving after reset release is ignored, because the target hart is IDLE.

Test Plan:
1. Reset release, hrun=4'b1111, sena=1 -> hstat=8'h55 after 1 cycle; dhart sequence 0,1,2,3,0 with dvld=1 from the second cycle; hidle=0.
2. hrun=4'b1111 steady, wreq with whart=1 -> hstat[3:2]=10; issue order 0,2,3,0,2; wack with ahart=1 -> hart 1 back in rotation after 0/2/3 per pointer.
3. xtrap with thart=2 while sena toggles 1,0,1,1,1 -> hart 2 stays TRAP for exactly 3 sena-high cycles then RUN; not issued during TRAP.
4. Same cycle xtrap thart=0 and wreq whart=0 -> hart 0 enters TRAP, not WAIT; a later wack with ahart=0 is ignored.
5. hrun=4'b0000 with hart 3 in WAIT -> harts 0-2 go IDLE; hidle stays 0 until wack with ahart=3, then hart 3 goes IDLE, hidle=1, dvld=0.
6. srst pulsed low mid-TRAP on hart 1 -> outputs immediately 0, hidle=1; after release with hrun=4'b0010 the first issue is dhart=1.
